// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers host ALU commands, issues them one at a time, collects results or timeouts into a response FIFO. Optional stats counters with `define ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_inst,
    input  logic [11:0] i_cmd_a,
    input  logic [11:0] i_cmd_b,
    output logic        o_alu_valid,
    output logic [2:0]  o_alu_inst,
    output logic [11:0] o_alu_data_a,
    output logic [11:0] o_alu_data_b,
    input  logic        i_alu_valid,
    input  logic [11:0] i_alu_data,
    input  logic        i_alu_overflow,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [11:0] o_rsp_data,
    output logic        o_rsp_overflow,
    output logic        o_rsp_timeout,
    output logic        o_busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0] o_stat_issued,
    output logic [15:0] o_stat_overflow,
    output logic [15:0] o_stat_timeout
`endif
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RSP_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state, w_next;
    logic [26:0]   r_cmd_mem [CMD_DEPTH];
    logic [CW-1:0] r_cmd_wr, r_cmd_rd;
    logic [CW:0]   r_cmd_cnt;
    logic [13:0]   r_rsp_mem [RSP_DEPTH];
    logic [RW-1:0] r_rsp_wr, r_rsp_rd;
    logic [RW:0]   r_rsp_cnt;
    logic [TW-1:0] r_cnt;
    logic          w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
    logic          w_rsp_push, w_rsp_pop, w_rsp_full;
    logic [13:0]   w_rsp_din, w_rsp_head;
    logic          w_to;

    assign w_cmd_full   = r_cmd_cnt == (CW+1)'(CMD_DEPTH);
    assign w_cmd_empty  = r_cmd_cnt == '0;
    assign w_rsp_full   = r_rsp_cnt == (RW+1)'(RSP_DEPTH);
    assign o_cmd_ready  = !w_cmd_full;
    assign w_cmd_push   = i_cmd_valid && !w_cmd_full;
    assign o_rsp_valid  = r_rsp_cnt != '0;
    assign w_rsp_pop    = o_rsp_valid && i_rsp_ready;
    assign w_rsp_head   = o_rsp_valid ? r_rsp_mem[r_rsp_rd] : '0;
    assign o_rsp_data     = w_rsp_head[13:2];
    assign o_rsp_overflow = w_rsp_head[1];
    assign o_rsp_timeout  = w_rsp_head[0];
    assign o_busy       = r_state != S_IDLE || !w_cmd_empty;
    assign w_to         = r_cnt == TW'(TIMEOUT - 1);

    // Command FIFO: push from host, pop on ISSUE; full refuses push even while popping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd_wr  <= '0;
            r_cmd_rd  <= '0;
            r_cmd_cnt <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_mem[r_cmd_wr] <= {i_cmd_inst, i_cmd_a, i_cmd_b};
                r_cmd_wr            <= r_cmd_wr + CW'(1);
            end
            if (w_cmd_pop) r_cmd_rd <= r_cmd_rd + CW'(1);
            r_cmd_cnt <= r_cmd_cnt + (CW+1)'(w_cmd_push) - (CW+1)'(w_cmd_pop);
        end
    end

    // Response FIFO: space is reserved before issue, so a push never meets a full FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_wr  <= '0;
            r_rsp_rd  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_mem[r_rsp_wr] <= w_rsp_din;
                r_rsp_wr            <= r_rsp_wr + RW'(1);
            end
            if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + RW'(1);
            r_rsp_cnt <= r_rsp_cnt + (RW+1)'(w_rsp_push) - (RW+1)'(w_rsp_pop);
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? S_IDLE : w_next;
    end

    // WAIT cycle counter, cleared on ISSUE
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == S_ISSUE) r_cnt <= '0;
        else if (r_state == S_WAIT) r_cnt <= r_cnt + TW'(1);
    end

    // Next state, ALU issue and response push; a result in the timeout cycle wins
    always_comb begin
        w_next       = r_state;
        w_cmd_pop    = 1'b0;
        w_rsp_push   = 1'b0;
        w_rsp_din    = '0;
        o_alu_valid  = 1'b0;
        o_alu_inst   = '0;
        o_alu_data_a = '0;
        o_alu_data_b = '0;
        case (r_state)
            S_IDLE: w_next = (!w_cmd_empty && !w_rsp_full) ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                w_cmd_pop = 1'b1;
                o_alu_valid = 1'b1;
                {o_alu_inst, o_alu_data_a, o_alu_data_b} = r_cmd_mem[r_cmd_rd];
                w_next = S_WAIT;
            end
            S_WAIT: begin
                w_rsp_push = i_alu_valid || w_to;
                w_rsp_din = i_alu_valid ? {i_alu_data, i_alu_overflow, 1'b0} : 14'h0001;
                w_next = w_rsp_push ? S_IDLE : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_stat_issued, r_stat_overflow, r_stat_timeout;

    assign o_stat_issued   = r_stat_issued;
    assign o_stat_overflow = r_stat_overflow;
    assign o_stat_timeout  = r_stat_timeout;

    // Saturating event counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_issued   <= '0;
            r_stat_overflow <= '0;
            r_stat_timeout  <= '0;
        end else begin
            if (o_alu_valid && r_stat_issued != 16'hFFFF) r_stat_issued <= r_stat_issued + 16'd1;
            if (w_rsp_push && w_rsp_din[1] && r_stat_overflow != 16'hFFFF) r_stat_overflow <= r_stat_overflow + 16'd1;
            if (w_rsp_push && w_rsp_din[0] && r_stat_timeout != 16'hFFFF) r_stat_timeout <= r_stat_timeout + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vector bench for alu_cmd_sequencer with a delayed-reply ALU model
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_inst = '0;
    logic [11:0] cmd_a = '0, cmd_b = '0;
    logic        alu_valid_o;
    logic [2:0]  alu_inst;
    logic [11:0] alu_a, alu_b;
    logic        alu_valid_i;
    logic [11:0] alu_data_i;
    logic        alu_ovf_i;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_data;
    logic        rsp_ovf, rsp_to, busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] st_iss, st_ovf, st_to;
`endif

    logic        m_valid = 1'b0, t_valid = 1'b0;
    logic [11:0] m_data = '0, t_data = '0;
    logic        m_ovf = 1'b0;
    int          m_delay = 1, m_cnt = 0;
    logic [11:0] m_res = '0;
    logic        m_rovf = 1'b0;
    int          n_issue = 0;
    int          n_chk = 0, n_fail = 0;

    assign alu_valid_i = m_valid | t_valid;
    assign alu_data_i  = m_valid ? m_data : t_data;
    assign alu_ovf_i   = m_valid & m_ovf;

    alu_cmd_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_inst(cmd_inst), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
        .o_alu_valid(alu_valid_o), .o_alu_inst(alu_inst),
        .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
        .i_alu_valid(alu_valid_i), .i_alu_data(alu_data_i), .i_alu_overflow(alu_ovf_i),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_overflow(rsp_ovf), .o_rsp_timeout(rsp_to),
        .o_busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .o_stat_issued(st_iss), .o_stat_overflow(st_ovf), .o_stat_timeout(st_to)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: signed 12-bit add, replies m_delay cycles after issue (0 = silent)
    always @(negedge clk) begin
        m_valid = 1'b0;
        if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_valid = 1'b1;
                m_data  = m_res;
                m_ovf   = m_rovf;
            end
        end
        if (alu_valid_o) begin
            n_issue = n_issue + 1;
            m_res   = 12'(alu_a + alu_b);
            m_rovf  = (alu_a[11] == alu_b[11]) && (m_res[11] != alu_a[11]);
            if (m_delay > 0) m_cnt = m_delay;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] i, input logic [11:0] a, input logic [11:0] b,
                            input int bound, output bit ok);
        cmd_valid = 1'b1;
        cmd_inst = i;
        cmd_a = a;
        cmd_b = b;
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  inst;
        logic [11:0] a, b;
        int          dly;
        logic [11:0] xd;
        logic        xo, xt;
        int          lat;
    } vec_t;

    vec_t        vt [6];
    logic [11:0] got [10];
    logic        got_to [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cyc, base, nacc, ngot;
        vt[0] = '{3'b000, 12'h005, 12'h003, 1, 12'h008, 1'b0, 1'b0, 4};
        vt[1] = '{3'b000, 12'h7FF, 12'h001, 1, 12'h800, 1'b1, 1'b0, 4};
        vt[2] = '{3'b011, 12'h800, 12'hFFF, 2, 12'h7FF, 1'b1, 1'b0, 5};
        vt[3] = '{3'b101, 12'h123, 12'h456, 0, 12'h000, 1'b0, 1'b1, 11};
        vt[4] = '{3'b111, 12'h0F0, 12'h00F, 8, 12'h0FF, 1'b0, 1'b0, 11};
        vt[5] = '{3'b010, 12'hABC, 12'h001, 7, 12'hABD, 1'b0, 1'b0, 10};

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_outputs", int'({alu_valid_o, alu_inst, alu_a, alu_b, rsp_valid, rsp_data, rsp_ovf, rsp_to, busy}), 0);

        for (int v = 0; v < 6; v++) begin
            m_delay = vt[v].dly;
            base = n_issue;
            push_cmd(vt[v].inst, vt[v].a, vt[v].b, 5, ok);
            chk($sformatf("v%0d_accept", v), int'(ok), 1);
            cyc = 1;
            chk($sformatf("v%0d_no_early_issue", v), int'(alu_valid_o), 0);
            while (!alu_valid_o && cyc < 30) begin tick(); cyc++; end
            chk($sformatf("v%0d_issue_cycle", v), cyc, 2);
            chk($sformatf("v%0d_alu_fields", v), int'({alu_inst, alu_a, alu_b}), int'({vt[v].inst, vt[v].a, vt[v].b}));
            chk($sformatf("v%0d_busy", v), int'(busy), 1);
            while (!rsp_valid && cyc < 40) begin tick(); cyc++; end
            chk($sformatf("v%0d_rsp_cycle", v), cyc, vt[v].lat);
            chk($sformatf("v%0d_rsp", v), int'({rsp_data, rsp_ovf, rsp_to}), int'({vt[v].xd, vt[v].xo, vt[v].xt}));
            chk($sformatf("v%0d_issues", v), n_issue - base, 1);
            chk($sformatf("v%0d_alu_idle", v), int'({alu_valid_o, alu_a}), 0);
`ifdef ALU_SEQ_STATS_EN
            if (v == 1) chk("stat_overflow", int'(st_ovf), 1);
`endif
            t_valid = 1'b1;
            t_data = 12'hFFF;
            tick();
            t_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_stray_hold", v), int'({rsp_valid, rsp_data, rsp_to, busy}), int'({1'b1, vt[v].xd, vt[v].xt, 1'b0}));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_single_entry", v), int'({rsp_valid, rsp_data}), 0);
        end

        // reset during WAIT, then a late ALU strobe
        m_delay = 0;
        push_cmd(3'b001, 12'h111, 12'h222, 5, ok);
        cyc = 0;
        while (!alu_valid_o && cyc < 10) begin tick(); cyc++; end
        tick();
        chk("rw_in_wait", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t_valid = 1'b1;
        t_data = 12'h5A5;
        tick();
        t_valid = 1'b0;
        chk("rw_outputs", int'({alu_valid_o, alu_a, rsp_valid, rsp_data, rsp_to, busy}), 0);
        chk("rw_cmd_ready", int'(cmd_ready), 1);
        repeat (12) tick();
        chk("rw_no_rsp_later", int'({rsp_valid, busy}), 0);

        // backpressure: response FIFO held full, then drained
        m_delay = 1;
        base = n_issue;
        nacc = 0;
        for (int k = 0; k < 10; k++) begin
            push_cmd(3'(k), 12'(k * 16), 12'h001, 30, ok);
            if (!ok) break;
            nacc++;
        end
        chk("bp_accepted", nacc, 8);
        chk("bp_cmd_ready", int'(cmd_ready), 0);
        chk("bp_issued", n_issue - base, 4);
        repeat (10) tick();
        chk("bp_issued_hold", n_issue - base, 4);
        chk("bp_rsp_valid", int'(rsp_valid), 1);
        ngot = 0;
        rsp_ready = 1'b1;
        fork
            begin
                for (int c = 0; c < 300 && ngot < 10; c++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        got[ngot] = rsp_data;
                        got_to[ngot] = rsp_to;
                        ngot++;
                    end
                    @(posedge clk);
                end
            end
            begin
                bit ok2;
                for (int k = 8; k < 10; k++) begin
                    push_cmd(3'(k), 12'(k * 16), 12'h001, 200, ok2);
                    chk($sformatf("bp_late_accept%0d", k), int'(ok2), 1);
                end
            end
        join
        #1;
        rsp_ready = 1'b0;
        chk("bp_drain_count", ngot, 10);
        for (int k = 0; k < 10; k++)
            if (k < ngot) chk($sformatf("bp_order%0d", k), int'({got[k], got_to[k]}), int'({12'(k * 16 + 1), 1'b0}));
        chk("bp_final_idle", int'({rsp_valid, busy}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator for the 12-bit ALU command interface. It buffers host commands (inst, a, b) in a command FIFO and issues them to the ALU one at a time.
- It waits for each ALU response, with a timeout, and returns {data, overflow, timeout} to the host through a response FIFO with a valid/ready handshake.
- It sits between the host/testbench controller and the ALU and is the only driver of the ALU's valid/data/inst inputs.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2
- RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2
- TIMEOUT, 8, maximum WAIT cycles before declaring no response; minimum 2

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_cmd_valid  input  1  host command present
- o_cmd_ready  output  1  command FIFO not full
- i_cmd_inst  input  3  ALU opcode, passed through opaque
- i_cmd_a  input  12  operand A, signed
- i_cmd_b  input  12  operand B, signed
- o_alu_valid  output  1  one-cycle issue strobe to ALU
- o_alu_inst  output  3  opcode to ALU
- o_alu_data_a  output  12  operand A to ALU
- o_alu_data_b  output  12  operand B to ALU
- i_alu_valid  input  1  ALU result strobe
- i_alu_data  input  12  ALU result
- i_alu_overflow  input  1  ALU overflow flag
- o_rsp_valid  output  1  response FIFO not empty
- i_rsp_ready  input  1  host pops response
- o_rsp_data  output  12  head response data
- o_rsp_overflow  output  1  head response overflow
- o_rsp_timeout  output  1  head response was a timeout
- o_busy  output  1  FSM not IDLE or command FIFO not empty

Behaviour:
- Reset (i_rst high at a clock edge): both FIFOs empty, FSM to IDLE, timeout counter 0. All outputs are 0 except o_cmd_ready, which is 1 in the cycle after reset releases.
- A reset during ISSUE or WAIT abandons the in-flight command. A late i_alu_valid arriving after reset is ignored.
- Command accept: when i_cmd_valid && o_cmd_ready, write {inst, a, b} at the tail.
  - o_cmd_ready = !cmd_full, with no bypass: a full FIFO refuses a push even in a cycle where it pops.
- Response FIFO: head is visible on o_rsp_*. A pop happens when o_rsp_valid && i_rsp_ready. A simultaneous push and pop on a full FIFO is legal, and the count is unchanged.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE: go to ISSUE if the command FIFO is non-empty and the response FIFO is not full. The response slot is guaranteed before issue because the ALU has no backpressure.
  - ISSUE, exactly one cycle: o_alu_valid=1, o_alu_* = head command, pop the command FIFO, clear the counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - If i_alu_valid is high, push {i_alu_data, i_alu_overflow, 0} and go to IDLE.
    - Otherwise, when the counter reaches TIMEOUT, push {12'h000, 0, 1} and go to IDLE.
    - If i_alu_valid and the timeout occur in the same cycle, the response wins.
- o_alu_valid/inst/data_a/data_b are 0 outside ISSUE.
- i_alu_valid outside WAIT is ignored: no push, no state change.
- Latency:
  - Command accepted at edge 0 → ISSUE during cycle 2.
  - With a 1-cycle ALU, i_alu_valid arrives in cycle 3 and o_rsp_valid rises in cycle 4.
  - Back-to-back throughput is one command per 3 cycles.
- Ordering: responses are returned strictly in command order, and timeouts hold their own slot.
- Data is passed through unmodified; the sequencer performs no arithmetic on operands or results.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, the block adds three 16-bit outputs:
  - o_stat_issued: increments on every ISSUE cycle.
  - o_stat_overflow: increments on every push with overflow=1.
  - o_stat_timeout: increments on every timeout push.
- All three counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and this logic are absent, and all other behaviour is identical.

Test Plan:
- ADD 0x005, 0x003 with a 1-cycle ALU model: o_alu_valid pulses once in cycle 2 with inst=000, a=0x005, b=0x003 → response in cycle 4 with data=0x008, overflow=0, timeout=0.
- ADD 0x7FF, 0x001 with the model returning 0x800, overflow=1 → response data=0x800, overflow=1. With ALU_SEQ_STATS_EN defined, o_stat_overflow=1.
- Silent ALU model, one command: WAIT lasts TIMEOUT=8 cycles → response data=0x000, overflow=0, timeout=1. A later stray i_alu_valid is ignored and the FIFO count stays 1.
- Hold i_rsp_ready=0 and push 10 commands:
  - 4 commands are issued, filling the response FIFO.
  - Then 4 commands queue and o_cmd_ready goes to 0.
  - No further o_alu_valid pulses occur.
  - After i_rsp_ready goes to 1, all 8 accepted results drain in order and the remaining commands are then accepted.
- Assert i_rst during WAIT, then send i_alu_valid in the next cycle → no response is pushed, all outputs are 0, and o_cmd_ready=1 after release.
- Response and timeout in the same cycle: the model replies on WAIT cycle 8 → the pushed response has timeout=0 and carries the model's data.
